// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer.
// Holds the state encoding and the default memory geometry.
package boot_pkg;

  localparam int ADDR_W     = 5;
  localparam int INSTR_W    = 14;
  localparam int IMEM_DEPTH = 1 << ADDR_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } boot_state_e;

endpackage

// File: rtl/imem_32x14.sv
// Instruction store: register array with a synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module imem_32x14 #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 14
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory while the core
// is held in reset, then releases it and serves zero-latency fetches on pc.
module imem_boot_ctrl #(
  parameter int          ADDR_W    = boot_pkg::ADDR_W,
  parameter int          INSTR_W   = boot_pkg::INSTR_W,
  parameter int unsigned RUN_LIMIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  input  logic               halt_req,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instraction,
  output logic               core_rst,
  output logic [1:0]         state,
  output logic [ADDR_W:0]    prog_len
);

  import boot_pkg::*;

  localparam logic [31:0] LIMIT_M1 = 32'(RUN_LIMIT - 1);

  boot_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    prog_len_q, prog_len_d;
  logic [31:0]        run_cnt_q, run_cnt_d;
  logic               core_rst_q;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_rdata;

  assign ld_ready = (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    run_cnt_d  = run_cnt_q;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end

      LOAD: begin
        if (ld_valid) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          // A full memory terminates the load so the pointer never wraps.
          if (ld_last || (&wr_ptr_q)) begin
            state_d   = RUN;
            run_cnt_d = '0;
          end
        end
      end

      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else if (halt_req || ((RUN_LIMIT != 0) && (run_cnt_q == LIMIT_M1))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      run_cnt_q  <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      run_cnt_q  <= run_cnt_d;
      core_rst_q <= (state_d != RUN);
    end
  end

  imem_32x14 #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (ld_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  // Words past the loaded length read as NOP, hiding stale or partial contents.
  assign instraction = ({1'b0, pc} < prog_len_q) ? mem_rdata : INSTR_W'(NOP_INSTR);
  assign core_rst    = core_rst_q;
  assign state       = state_q;
  assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with RUN_LIMIT=10; expected values are
// hand-computed constants checked by immediate assertions.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [13:0] ld_data;
  logic        ld_last;
  logic        halt_req;
  logic [4:0]  pc;
  logic [13:0] instraction;
  logic        core_rst;
  logic [1:0]  state;
  logic [5:0]  prog_len;

  int checks   = 0;
  int failures = 0;
  int accepted;

  imem_boot_ctrl #(
    .ADDR_W    (5),
    .INSTR_W   (14),
    .RUN_LIMIT (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .halt_req    (halt_req),
    .pc          (pc),
    .instraction (instraction),
    .core_rst    (core_rst),
    .state       (state),
    .prog_len    (prog_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [4:0] addr, input logic [13:0] exp);
    pc = addr;
    #1;
    chk(tag, 32'(instraction), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; halt_req = 1'b0; pc = '0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    fetch("rst_fetch", 5'd0, 14'h0000);
    tick(); tick();
    rst = 1'b0;

    // IDLE ignores the loader stream
    ld_valid = 1'b1; ld_data = 14'h1234;
    tick();
    ld_valid = 1'b0;
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_ld_ready", 32'(ld_ready), 32'd0);
    chk("idle_prog_len", 32'(prog_len), 32'd0);

    // 5-word load terminated by ld_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t1_load_state", 32'(state), 32'd1);
    chk("t1_load_ready", 32'(ld_ready), 32'd1);
    chk("t1_load_core_rst", 32'(core_rst), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      ld_valid = 1'b1; ld_data = 14'(i); ld_last = (i == 5);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("t1_run_state", 32'(state), 32'd2);
    chk("t1_run_core_rst", 32'(core_rst), 32'd0);
    chk("t1_prog_len", 32'(prog_len), 32'd5);
    chk("t1_run_ready", 32'(ld_ready), 32'd0);
    fetch("t1_pc3", 5'd3, 14'h0004);
    fetch("t1_pc7", 5'd7, 14'h0000);
    fetch("t1_pc4", 5'd4, 14'h0005);
    fetch("t1_pc5", 5'd5, 14'h0000);

    // Run budget: 10 RUN cycles (run_cnt 0..9), DONE on the 11th
    for (int i = 0; i < 9; i++) tick();
    chk("t3_run_cycle10_state", 32'(state), 32'd2);
    chk("t3_run_cycle10_core_rst", 32'(core_rst), 32'd0);
    tick();
    chk("t3_done_state", 32'(state), 32'd3);
    chk("t3_done_core_rst", 32'(core_rst), 32'd1);
    fetch("t3_done_retained", 5'd0, 14'h0001);

    // Load with ld_valid toggling; stale mem[4] must stay masked
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t6_load_state", 32'(state), 32'd1);
    chk("t6_prog_len_clr", 32'(prog_len), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 14'h0100 + 14'(i); ld_last = (i == 3);
      tick();
      if (i < 3) begin
        ld_valid = 1'b0; ld_data = 14'h3FFF; ld_last = 1'b1;
        tick();
        chk("t6_gap_prog_len", 32'(prog_len), 32'(i + 1));
        chk("t6_gap_state", 32'(state), 32'd1);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("t6_run_state", 32'(state), 32'd2);
    chk("t6_prog_len", 32'(prog_len), 32'd4);
    fetch("t6_pc0", 5'd0, 14'h0100);
    fetch("t6_pc1", 5'd1, 14'h0101);
    fetch("t6_pc2", 5'd2, 14'h0102);
    fetch("t6_pc3", 5'd3, 14'h0103);
    fetch("t6_pc4_masked", 5'd4, 14'h0000);

    // load_start beats halt_req in RUN
    halt_req = 1'b1; load_start = 1'b1;
    tick();
    halt_req = 1'b0; load_start = 1'b0;
    chk("t4_state", 32'(state), 32'd1);
    chk("t4_core_rst", 32'(core_rst), 32'd1);
    chk("t4_prog_len", 32'(prog_len), 32'd0);
    chk("t4_ld_ready", 32'(ld_ready), 32'd1);
    fetch("t4_fetch_masked", 5'd0, 14'h0000);

    // 40 offered words without ld_last: only 32 accepted
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      ld_valid = 1'b1; ld_data = 14'h0200 + 14'(i);
      #1;
      if (ld_ready) accepted++;
      if (i == 32) begin
        chk("t2_after32_state", 32'(state), 32'd2);
        chk("t2_after32_ready", 32'(ld_ready), 32'd0);
        chk("t2_after32_core_rst", 32'(core_rst), 32'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("t2_accepted", 32'(accepted), 32'd32);
    chk("t2_prog_len", 32'(prog_len), 32'd32);
    chk("t2_state", 32'(state), 32'd2);
    fetch("t2_pc31", 5'd31, 14'h021F);
    fetch("t2_pc0", 5'd0, 14'h0200);

    // halt_req alone ends the run early (run_cnt is 8 here)
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_core_rst", 32'(core_rst), 32'd1);
    chk("halt_prog_len", 32'(prog_len), 32'd32);

    // Async reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 14'h0300 + 14'(i);
      tick();
    end
    chk("t5_pre_prog_len", 32'(prog_len), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_core_rst", 32'(core_rst), 32'd1);
    chk("t5_ld_ready", 32'(ld_ready), 32'd0);
    chk("t5_prog_len", 32'(prog_len), 32'd0);
    fetch("t5_pc0", 5'd0, 14'h0000);
    fetch("t5_pc31", 5'd31, 14'h0000);
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_post_state", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
